// File: rtl/buff_arb_pkg.sv
// rtl/buff_arb_pkg.sv - shared types and sizing helpers for the round-robin burst arbiter
package buff_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 32;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int SRC_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  // Scan from the farthest slot back to ptr so the closest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/buff_rr_arbiter.sv
// rtl/buff_rr_arbiter.sv - round-robin burst arbiter feeding one registered output stage
module buff_rr_arbiter
  import buff_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  localparam int SW       = SRC_W(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SW-1:0]             out_src,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  arb_state_t  state, state_nxt;
  logic [SW-1:0] ptr;
  logic [SW-1:0] owner;
  logic [3:0]    beat_cnt;

  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          out_free;
  logic          accept;
  logic          release_beat;
  logic [DATA_W-1:0] owner_data;
  logic [SW-1:0] owner_next;

  rr_pick #(.N(NUM_REQ), .W(SW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_free     = !out_valid || out_ready;
  assign accept       = (state == BURST) && req_valid[owner] && out_free;
  assign release_beat = accept && (req_last[owner] || beat_cnt == 4'(MAX_BURST - 1));
  assign owner_data   = req_data[int'(owner) * DATA_W +: DATA_W];
  assign owner_next   = (owner == SW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy         = (state == BURST);

  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[owner] = out_free;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = BURST;
      BURST:   if (release_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Owner and ptr only move at arbitration and release; other requesters cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) owner <= pick_idx;
      if (accept) begin
        out_data  <= owner_data;
        out_src   <= owner;
        out_last  <= release_beat;
        out_valid <= 1'b1;
        beat_cnt  <= release_beat ? 4'd0 : beat_cnt + 4'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (release_beat) ptr <= owner_next;
    end
  end

endmodule

// File: tb/tb_buff_rr_arbiter.sv
// tb/tb_buff_rr_arbiter.sv - directed table and sequence bench for buff_rr_arbiter
module tb_buff_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_last  = '0;
  logic [127:0] req_data  = '0;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  buff_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        ordy;
    logic [27:0] d;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [31:0] e_d;
    logic [1:0]  e_src;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] d;
    logic        last;
  } beat_t;

  vec_t  vecs[$];
  beat_t got[$];
  beat_t exp4[8];
  int    n0, n1, n2;
  logic [31:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rv, input logic [3:0] rl,
                              input logic ordy, input logic [27:0] d, input logic [3:0] e_rdy,
                              input logic e_v, input logic [31:0] e_d, input logic [1:0] e_src,
                              input logic e_last, input logic e_busy);
    vec_t v;
    v.rst = r; v.rv = rv; v.rl = rl; v.ordy = ordy; v.d = d; v.e_rdy = e_rdy;
    v.e_v = e_v; v.e_d = e_d; v.e_src = e_src; v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic [3:0] rl);
    @(negedge clk);
    rst = r; req_valid = rv; req_last = rl;
    #1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state and idle behaviour
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      post();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
    end

    // Single burst on req0, then round-robin with 1-beat bursts, then ptr=2 with req1/req3
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 28'hA1, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 28'hA1, 4'b0001, 1, 32'h000000A1, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 28'hA2, 4'b0001, 1, 32'h000000A2, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 28'hA3, 4'b0001, 1, 32'h000000A3, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 28'h0,  4'b0000, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 28'hB0, 4'b0000, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB0, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB0, 4'b0001, 1, 32'h000000B0, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB1, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB1, 4'b0010, 1, 32'h100000B1, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB2, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB2, 4'b0100, 1, 32'h200000B2, 2, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB3, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB3, 4'b1000, 1, 32'h300000B3, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB4, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 28'hB4, 4'b0001, 1, 32'h000000B4, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 28'hB5, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 28'hB5, 4'b0010, 1, 32'h100000B5, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 28'hB6, 4'b0000, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 28'hB6, 4'b1000, 1, 32'h300000B6, 3, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].rv; req_last = vecs[i].rl;
      out_ready = vecs[i].ordy;
      for (int l = 0; l < 4; l++) req_data[l*32 +: 32] = {4'(l), vecs[i].d};
      #1;
      chk($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_rdy);
      post();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_v);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_d);
        chk($sformatf("vec%0d_out_src", i), out_src, vecs[i].e_src);
        chk($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_last);
      end
    end

    // MAX_BURST cut: req2 streams 6 beats without last; req1 waits and is served in between
    do_reset();
    n1 = 0; n2 = 0; got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0;
      req_valid[1] = (n1 < 2);
      req_last[1]  = 1'b1;
      req_valid[2] = (n1 >= 1) && (n2 < 6);
      req_data[1*32 +: 32] = 32'h100000D0 + 32'(n1);
      req_data[2*32 +: 32] = 32'h200000C0 + 32'(n2);
      #1;
      if (req_ready[1] && req_valid[1]) n1++;
      if (req_ready[2] && req_valid[2]) n2++;
      post();
      if (out_valid) got.push_back('{src: out_src, d: out_data, last: out_last});
    end
    exp4[0] = '{src: 2'd1, d: 32'h100000D0, last: 1'b1};
    exp4[1] = '{src: 2'd2, d: 32'h200000C0, last: 1'b0};
    exp4[2] = '{src: 2'd2, d: 32'h200000C1, last: 1'b0};
    exp4[3] = '{src: 2'd2, d: 32'h200000C2, last: 1'b0};
    exp4[4] = '{src: 2'd2, d: 32'h200000C3, last: 1'b1};
    exp4[5] = '{src: 2'd1, d: 32'h100000D1, last: 1'b1};
    exp4[6] = '{src: 2'd2, d: 32'h200000C4, last: 1'b0};
    exp4[7] = '{src: 2'd2, d: 32'h200000C5, last: 1'b0};
    chk("maxb_beat_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        chk($sformatf("maxb%0d_src", i), got[i].src, exp4[i].src);
        chk($sformatf("maxb%0d_data", i), got[i].d, exp4[i].d);
        chk($sformatf("maxb%0d_last", i), got[i].last, exp4[i].last);
      end
    end

    // Backpressure: out_ready low for 5 cycles while req0 streams 4 beats
    do_reset();
    n0 = 0; got.delete(); held = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = '0; req_last = '0;
      req_valid[0] = (n0 < 4);
      req_last[0]  = (n0 == 3);
      req_data[31:0] = 32'h000000E0 + 32'(n0);
      out_ready = !(c >= 4 && c < 9);
      #1;
      if (c == 4) held = out_data;
      if (out_valid && !out_ready) begin
        chk($sformatf("stall%0d_req_ready", c), req_ready, 0);
        chk($sformatf("stall%0d_out_data", c), out_data, held);
      end
      if (out_valid && out_ready) got.push_back('{src: out_src, d: out_data, last: out_last});
      if (req_ready[0] && req_valid[0]) n0++;
      post();
    end
    chk("bp_held_value", held, 32'h000000E2);
    chk("bp_beat_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk($sformatf("bp%0d_data", i), got[i].d, 32'h000000E0 + 32'(i));
        chk($sformatf("bp%0d_last", i), got[i].last, (i == 3));
      end
    end
    out_ready = 1'b1;

    // Reset mid-burst: ptr is moved to 2, req2 burst interrupted, req0 must win afterwards
    do_reset();
    req_data[0*32 +: 32] = 32'h000000F0;
    req_data[1*32 +: 32] = 32'h100000F1;
    req_data[2*32 +: 32] = 32'h200000F2;
    drive(0, 4'b0010, 4'b0010); post();
    drive(0, 4'b0010, 4'b0010); post();
    drive(0, 4'b0100, 4'b0000); post();
    drive(0, 4'b0100, 4'b0000); post();
    drive(0, 4'b0100, 4'b0000); post();
    chk("mid_pre_out_valid", out_valid, 1);
    chk("mid_pre_out_src", out_src, 2);
    drive(1, 4'b0100, 4'b0000); post();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_src", out_src, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    drive(0, 4'b0101, 4'b0101);
    chk("mid_idle_req_ready", req_ready, 0);
    post();
    chk("mid_arb_busy", busy, 1);
    drive(0, 4'b0101, 4'b0101);
    chk("mid_grant_req_ready", req_ready, 4'b0001);
    post();
    chk("mid_grant_out_valid", out_valid, 1);
    chk("mid_grant_out_src", out_src, 0);
    chk("mid_grant_out_data", out_data, 32'h000000F0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
